dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte enables are compiled in with DMEM_RESP_BYTE_EN.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word store: synchronous write with byte lanes, registered read.
// Read register clears on reset or on an erroring access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Storage is intentionally never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency MEM-stage data memory responder with hazard stall.
// Define DMEM_RESP_BYTE_EN to add the req_be store byte-lane port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_RESP_BYTE_EN
  input  logic [BE_W-1:0]   req_be,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [CNT_W-1:0] LAT_INIT =
    CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [BE_W-1:0]   be_q, in_be;
  logic              err_q;
  logic              capture, go_resp, ready;
  logic              acc_we, acc_err;
  logic [WORD_W-1:0] acc_addr, acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              arr_we, arr_re, arr_clr;

`ifdef DMEM_RESP_BYTE_EN
  assign in_be = req_be;
`else
  assign in_be = '1;
`endif

  assign capture = (state_q == IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    stall   = 1'b0;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req_valid) begin
          stall = 1'b1;
          cnt_d = LAT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // LATENCY==1 enters RESP straight from IDLE, so use live inputs there.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = in_be;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   ((acc_addr >> (ADDR_W + 2)) != '0);

  assign arr_we  = go_resp && acc_we && !acc_err &&
                   (|acc_be);
  assign arr_re  = go_resp && !acc_we && !acc_err;
  assign arr_clr = go_resp && acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= go_resp && acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (capture) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= in_be;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .addr_i  (acc_addr[ADDR_W+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (rsp_rdata)
  );

  assign req_ready = ready && rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: LATENCY=2 instance and LATENCY=1 instance.
// Byte-lane cases run when DMEM_RESP_BYTE_EN is defined.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  vld, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];

  logic        a_rdy, a_rv, a_er, a_stl;
  logic        b_rdy, b_rv, b_er, b_stl;
  logic [31:0] a_rd, b_rd;
  logic [1:0]  rdy, rv, er, stl;
  logic [31:0] rd [2];

  assign rdy   = {b_rdy, a_rdy};
  assign rv    = {b_rv, a_rv};
  assign er    = {b_er, a_er};
  assign stl   = {b_stl, a_stl};
  assign rd[0] = a_rd;
  assign rd[1] = b_rd;

  int n_checks = 0;
  int n_err    = 0;

  exp_t        sb0[$], sb1[$];
  logic [31:0] mdl0 [256];
  logic [31:0] mdl1 [256];
  logic [31:0] last [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W  (8),
    .LATENCY (2)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld[0]),
    .req_we    (we[0]),
    .req_addr  (addr[0]),
    .req_wdata (wdata[0]),
`ifdef DMEM_RESP_BYTE_EN
    .req_be    (be[0]),
`endif
    .req_ready (a_rdy),
    .rsp_valid (a_rv),
    .rsp_rdata (a_rd),
    .rsp_err   (a_er),
    .stall     (a_stl)
  );

  dmem_responder #(
    .ADDR_W  (8),
    .LATENCY (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld[1]),
    .req_we    (we[1]),
    .req_addr  (addr[1]),
    .req_wdata (wdata[1]),
`ifdef DMEM_RESP_BYTE_EN
    .req_be    (be[1]),
`endif
    .req_ready (b_rdy),
    .rsp_valid (b_rv),
    .rsp_rdata (b_rd),
    .rsp_err   (b_er),
    .stall     (b_stl)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic predict(input int d,
                         input logic w,
                         input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] b);
    exp_t        e;
    logic [31:0] cur;
    logic [7:0]  i;
    logic [3:0]  eb;
    eb = b;
`ifndef DMEM_RESP_BYTE_EN
    eb = 4'hF;
`endif
    i     = a[9:2];
    e.err = (a[1:0] != 2'b00) || (a[31:10] != '0);
    cur   = (d == 0) ? mdl0[i] : mdl1[i];
    if (e.err) begin
      e.rdata = '0;
    end else if (!w) begin
      e.rdata = cur;
    end else begin
      e.rdata = last[d];
      for (int k = 0; k < 4; k++)
        if (eb[k]) cur[8*k +: 8] = wd[8*k +: 8];
      if (d == 0) mdl0[i] = cur;
      else mdl1[i] = cur;
    end
    last[d] = e.rdata;
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic access(input int d,
                        input logic w,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0] b,
                        input int lat);
    int n;
    n = 0;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", rdy[d], 1);
    vld[d]   = 1'b1;
    we[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    be[d]    = b;
    predict(d, w, a, wd, b);
    #1;
    check("stall_accept", stl[d], 1);
    @(posedge clk);
    #1;
    vld[d]   = 1'b0;
    we[d]    = ~w;
    addr[d]  = 32'h0000_0013;
    wdata[d] = ~wd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("rsp_latency", rv[d], k == lat);
      check("stall_busy", stl[d], k < lat);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rv[0]) begin
      check("sb0_pending", sb0.size() > 0, 1);
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        check("rdata0", rd[0], e.rdata);
        check("err0", er[0], e.err);
      end
    end
    if (rv[1]) begin
      check("sb1_pending", sb1.size() > 0, 1);
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        check("rdata1", rd[1], e.rdata);
        check("err1", er[1], e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld [4];
    rst  = 1'b0;
    vld  = '0;
    we   = '0;
    last[0] = '0;
    last[1] = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d]  = '0;
      wdata[d] = '0;
      be[d]    = 4'hF;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", rdy, 2'b00);
    check("rst_rvalid", rv, 2'b00);
    check("rst_err", er, 2'b00);
    check("rst_rdata0", rd[0], 0);
    check("rst_rdata1", rd[1], 0);
    rst = 1'b1;
    #1;
    check("rel_ready", rdy, 2'b11);
    check("rel_stall", stl, 2'b00);
    check("rel_rvalid", rv, 2'b00);

    access(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2);
    access(0, 0, 32'h10, 32'h0, 4'hF, 2);
    access(0, 0, 32'h13, 32'h0, 4'hF, 2);
    access(0, 0, 32'h400, 32'h0, 4'hF, 2);
    access(0, 0, 32'h10, 32'h0, 4'hF, 2);
    access(0, 1, 32'h3FC, 32'h0BAD_CAFE, 4'hF, 2);
    access(0, 1, 32'h20, 32'hCAFE_F00D, 4'hF, 2);
    access(0, 0, 32'h3FC, 32'h0, 4'hF, 2);

    @(negedge clk);
    vld[0]   = 1'b1;
    we[0]    = 1'b1;
    addr[0]  = 32'h20;
    wdata[0] = 32'h1122_3344;
    be[0]    = 4'hF;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    @(negedge clk);
    check("mid_wait_stall", stl[0], 1);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", rdy[0], 0);
    check("mid_rst_stall", stl[0], 0);
    check("mid_rst_rvalid", rv[0], 0);
    @(negedge clk);
    rst = 1'b1;
    last[0] = '0;
    last[1] = '0;
    #1;
    check("mid_rst_idle", rdy[0], 1);
    check("mid_rst_rdata", rd[0], 0);
    access(0, 0, 32'h20, 32'h0, 4'hF, 2);

    ld[0] = 32'h40;
    ld[1] = 32'h44;
    ld[2] = 32'h48;
    ld[3] = 32'h4C;
    for (int i = 0; i < 4; i++)
      access(1, 1, ld[i], 32'h1000_0001 * (i + 3),
             4'hF, 1);
    vld[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready", rdy[1], 1);
      we[1]   = 1'b0;
      addr[1] = ld[3 - i];
      predict(1, 0, ld[3 - i], 32'h0, 4'hF);
      @(posedge clk);
      #1;
      we[1]    = 1'b1;
      addr[1]  = 32'h0000_0013;
      wdata[1] = 32'h5555_5555;
      @(negedge clk);
      check("b2b_rsp", rv[1], 1);
      check("b2b_busy", rdy[1], 0);
    end
    vld[1] = 1'b0;
    @(negedge clk);
    check("b2b_idle", rv[1], 0);
    access(1, 0, 32'h40, 32'h0, 4'hF, 1);

`ifdef DMEM_RESP_BYTE_EN
    access(0, 1, 32'h30, 32'h0, 4'hF, 2);
    access(0, 1, 32'h30, 32'hAABB_CCDD, 4'b0101, 2);
    access(0, 0, 32'h30, 32'h0, 4'hF, 2);
    access(0, 1, 32'h30, 32'hFFFF_FFFF, 4'b0000, 2);
    access(0, 0, 32'h30, 32'h0, 4'hF, 2);
    access(0, 1, 32'h30, 32'h1234_5678, 4'b1000, 2);
    access(0, 0, 32'h30, 32'h0, 4'hF, 2);
`endif

    repeat (3) @(negedge clk);
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
